// File: rtl/aes_sbox_ctrl_pkg.sv
// Shared types and sizing helpers for the masked AES S-box issue controller.
package aes_sbox_ctrl_pkg;

  localparam int LATENCY_DEF = 4;
  localparam int MAX_ID_W    = 2;
  localparam int BLIND_NRND  = 5;

  function automatic int reqIdW(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  // Multiplier, inverter and blinding randomness drawn each cycle by the S-box.
  function automatic int rndWidth(input int shares);
    int pairs;
    pairs = shares * (shares - 1);
    return 3 * 2 * pairs + 3 * pairs + 3 * 2 * BLIND_NRND;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } rspTag_t;

endpackage

// File: rtl/aes_sbox_issue_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting at the pointer, pointer advances past each grant.
module rr_arbiter import aes_sbox_ctrl_pkg::*; #(
  parameter  int NREQ = 2,
  localparam int ID_W = reqIdW(NREQ)
) (
  input  logic            ClkxCI,
  input  logic            RstxRI,
  input  logic            advance,
  input  logic [NREQ-1:0] reqValid,
  output logic [NREQ-1:0] grantOh,
  output logic [ID_W-1:0] grantIdx,
  output logic            anyValid,
  output logic [ID_W-1:0] ptr
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;
  logic [ID_W-1:0] nextPtr;

  always_comb begin
    grantIdx = ptr;
    anyValid = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NREQ)) sum = sum - (ID_W+1)'(NREQ);
      idx = sum[ID_W-1:0];
      if (!anyValid && reqValid[idx]) begin
        anyValid = 1'b1;
        grantIdx = idx;
      end
    end
  end

  always_comb begin
    grantOh = '0;
    if (anyValid) grantOh[grantIdx] = 1'b1;
  end

  assign nextPtr = (grantIdx == ID_W'(NREQ - 1)) ? '0 : grantIdx + ID_W'(1);

  always_ff @(posedge ClkxCI) begin
    if (RstxRI)       ptr <= '0;
    else if (advance) ptr <= nextPtr;
  end

endmodule

// File: rtl/aes_sbox_issue_ctrl.sv
// Issue controller sharing one pipelined masked AES S-box between NREQ requesters.
// Optional SBOX_IDLE_ZERO_EN: drive zero into the S-box on cycles without an issue.
module aes_sbox_issue_ctrl import aes_sbox_ctrl_pkg::*; #(
  parameter  int SHARES  = 2,
  parameter  int NREQ    = 2,
  parameter  int LATENCY = LATENCY_DEF,
  parameter  int RND_W   = rndWidth(SHARES),
  localparam int ID_W    = reqIdW(NREQ),
  localparam int DW      = 8 * SHARES
) (
  input  logic                 ClkxCI,
  input  logic                 RstxRI,
  input  logic                 EnxSI,
  input  logic [NREQ-1:0]      ReqValidxSI,
  output logic [NREQ-1:0]      ReqReadyxSO,
  input  logic [NREQ*DW-1:0]   ReqDataxDI,
  input  logic                 RndValidxSI,
  input  logic [RND_W-1:0]     RndxDI,
  output logic                 RndReadyxSO,
  output logic [DW-1:0]        SbXxDO,
  output logic [RND_W-1:0]     SbRndxDO,
  input  logic [DW-1:0]        SbQxDI,
  output logic                 RspValidxSO,
  output logic [ID_W-1:0]      RspIdxDO,
  output logic [DW-1:0]        RspQxDO,
  output logic                 BusyxSO,
  output logic                 RndErrxSO
);

  logic [NREQ-1:0] grantOh;
  logic [ID_W-1:0] grantIdx;
  logic [ID_W-1:0] rrPtr;
  logic [ID_W-1:0] selIdx;
  logic            anyValid;
  logic            issue;
  logic            busyInt;
  logic            unusedIdBits;
  rspTag_t         tagPipe [LATENCY];
  rspTag_t         rspTag;

  assign issue = ~RstxRI & EnxSI & RndValidxSI & anyValid;

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .ClkxCI   (ClkxCI),
    .RstxRI   (RstxRI),
    .advance  (issue),
    .reqValid (ReqValidxSI),
    .grantOh  (grantOh),
    .grantIdx (grantIdx),
    .anyValid (anyValid),
    .ptr      (rrPtr)
  );

  assign ReqReadyxSO = issue ? grantOh : '0;
  assign selIdx      = issue ? grantIdx : rrPtr;

  always_comb begin
    SbXxDO = '0;
`ifdef SBOX_IDLE_ZERO_EN
    if (issue) begin
`else
    begin
`endif
      for (int r = 0; r < NREQ; r++) begin
        if (selIdx == ID_W'(r)) SbXxDO = ReqDataxDI[r*DW +: DW];
      end
    end
  end

  // The S-box cannot stall, so randomness is drawn whenever anything is in its pipeline.
  assign RndReadyxSO = ~RstxRI & RndValidxSI & (issue | busyInt);
  assign SbRndxDO    = RndReadyxSO ? RndxDI : '0;

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      for (int k = 0; k < LATENCY; k++) tagPipe[k] <= '0;
    end else begin
      tagPipe[0] <= '{valid: issue, id: MAX_ID_W'(grantIdx)};
      for (int k = 1; k < LATENCY; k++) tagPipe[k] <= tagPipe[k-1];
    end
  end

  always_comb begin
    busyInt = 1'b0;
    for (int k = 0; k < LATENCY; k++) busyInt = busyInt | tagPipe[k].valid;
  end

  assign rspTag       = tagPipe[LATENCY-1];
  assign unusedIdBits = ^rspTag.id;
  assign RspValidxSO  = rspTag.valid & ~RstxRI;
  assign RspIdxDO     = RstxRI ? '0 : rspTag.id[ID_W-1:0];
  assign RspQxDO      = SbQxDI;
  assign BusyxSO      = busyInt & ~RstxRI;

  // Sticky: in-flight ops lost their fresh masks, so their results are no longer protected.
  always_ff @(posedge ClkxCI) begin
    if (RstxRI)                        RndErrxSO <= 1'b0;
    else if (busyInt && !RndValidxSI)  RndErrxSO <= 1'b1;
  end

endmodule

// File: tb/tb_aes_sbox_issue_ctrl.sv
// Randomized scoreboard bench for aes_sbox_issue_ctrl with a behavioural S-box and arbitration model.
module tb_aes_sbox_issue_ctrl;

  localparam int SHARES  = 2;
  localparam int NREQ    = 2;
  localparam int LATENCY = 4;
  localparam int RND_W   = 48;
  localparam int ID_W    = 1;
  localparam int DW      = 8 * SHARES;

  logic                ClkxCI = 1'b0;
  logic                RstxRI;
  logic                EnxSI;
  logic [NREQ-1:0]     ReqValidxSI;
  logic [NREQ-1:0]     ReqReadyxSO;
  logic [NREQ*DW-1:0]  ReqDataxDI;
  logic                RndValidxSI;
  logic [RND_W-1:0]    RndxDI;
  logic                RndReadyxSO;
  logic [DW-1:0]       SbXxDO;
  logic [RND_W-1:0]    SbRndxDO;
  logic [DW-1:0]       SbQxDI;
  logic                RspValidxSO;
  logic [ID_W-1:0]     RspIdxDO;
  logic [DW-1:0]       RspQxDO;
  logic                BusyxSO;
  logic                RndErrxSO;

  aes_sbox_issue_ctrl #(
    .SHARES(SHARES), .NREQ(NREQ), .LATENCY(LATENCY), .RND_W(RND_W)
  ) dut (
    .ClkxCI(ClkxCI), .RstxRI(RstxRI), .EnxSI(EnxSI),
    .ReqValidxSI(ReqValidxSI), .ReqReadyxSO(ReqReadyxSO), .ReqDataxDI(ReqDataxDI),
    .RndValidxSI(RndValidxSI), .RndxDI(RndxDI), .RndReadyxSO(RndReadyxSO),
    .SbXxDO(SbXxDO), .SbRndxDO(SbRndxDO), .SbQxDI(SbQxDI),
    .RspValidxSO(RspValidxSO), .RspIdxDO(RspIdxDO), .RspQxDO(RspQxDO),
    .BusyxSO(BusyxSO), .RndErrxSO(RndErrxSO)
  );

  always #5 ClkxCI = ~ClkxCI;

  int cyc = 0;
  always @(posedge ClkxCI) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         id;
    logic [7:0] val;
    int         due;
  } exp_t;
  exp_t expQ[$];

  int mPtr    = 0;
  bit mRndErr = 1'b0;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Multiplicative inverse as x^254, then the AES affine map.
  function automatic logic [7:0] aesSbox(input logic [7:0] x);
    logic [7:0] inv  = 8'h01;
    logic [7:0] base = x;
    int e = 254;
    while (e > 0) begin
      if ((e & 1) == 1) inv = gfMul(inv, base);
      base = gfMul(base, base);
      e = e >> 1;
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  // Stand-in for the masked S-box: fixed latency, output re-masked with a fresh byte.
  logic [DW-1:0] sbPipe   [LATENCY];
  logic [7:0]    maskPipe [LATENCY];
  initial begin
    for (int k = 0; k < LATENCY; k++) begin
      sbPipe[k]   = '0;
      maskPipe[k] = '0;
    end
  end
  always @(posedge ClkxCI) begin
    sbPipe[0]   <= SbXxDO;
    maskPipe[0] <= 8'($urandom());
    for (int k = 1; k < LATENCY; k++) begin
      sbPipe[k]   <= sbPipe[k-1];
      maskPipe[k] <= maskPipe[k-1];
    end
  end
  assign SbQxDI = {aesSbox(sbPipe[LATENCY-1][7:0] ^ sbPipe[LATENCY-1][15:8]) ^ maskPipe[LATENCY-1],
                   maskPipe[LATENCY-1]};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit en, input logic [NREQ-1:0] rv,
                               input bit rndv, input logic [NREQ*DW-1:0] data,
                               input logic [RND_W-1:0] rnd);
    int  c;
    bit  busy;
    bit  issue;
    int  g;
    int  rvInt;
    logic [DW-1:0] expX;
    logic [DW-1:0] gData;
    bit  expRndReady;
    @(posedge ClkxCI);
    #1;
    RstxRI      = rst;
    EnxSI       = en;
    ReqValidxSI = rv;
    RndValidxSI = rndv;
    ReqDataxDI  = data;
    RndxDI      = rnd;
    #1;
    c     = cyc;
    rvInt = int'(rv);
    busy  = 1'b0;
    foreach (expQ[i]) if (expQ[i].due - LATENCY < c) busy = 1'b1;
    issue = !rst && en && rndv && (rvInt != 0);
    g = mPtr;
    if (issue) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (((rvInt >> ((mPtr + i) % NREQ)) & 1) == 1) g = (mPtr + i) % NREQ;
      end
    end
    gData = DW'(data >> (g * DW));
`ifdef SBOX_IDLE_ZERO_EN
    expX = issue ? gData : '0;
`else
    expX = gData;
`endif
    expRndReady = !rst && rndv && (issue || busy);
    checkOutput("ReqReady", 64'(ReqReadyxSO), issue ? 64'(1 << g) : 64'(0));
    checkOutput("SbX",      64'(SbXxDO),      64'(expX));
    checkOutput("RndReady", 64'(RndReadyxSO), 64'(expRndReady));
    checkOutput("SbRnd",    64'(SbRndxDO),    expRndReady ? 64'(rnd) : 64'(0));
    checkOutput("Busy",     64'(BusyxSO),     64'(!rst && busy));
    checkOutput("RndErr",   64'(RndErrxSO),   64'(mRndErr));
    if (rst) begin
      expQ.delete();
      mPtr    = 0;
      mRndErr = 1'b0;
    end else begin
      if (busy && !rndv) mRndErr = 1'b1;
      if (issue) begin
        expQ.push_back('{id: g, val: aesSbox(gData[7:0] ^ gData[15:8]), due: c + LATENCY});
        mPtr = (g + 1) % NREQ;
      end
    end
  endtask

  // Monitor: every presented response must match the oldest outstanding op and arrive on time.
  always @(negedge ClkxCI) begin
    exp_t e;
    if (RspValidxSO === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("RspSpurious", 64'(RspValidxSO), 64'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("RspDue", 64'(cyc), 64'(e.due));
        checkOutput("RspId",  64'(RspIdxDO), 64'(e.id));
        checkOutput("RspQ",   64'(RspQxDO[7:0] ^ RspQxDO[15:8]), 64'(e.val));
      end
    end else if (expQ.size() != 0 && expQ[0].due <= cyc) begin
      e = expQ.pop_front();
      checkOutput("RspMissing", 64'(RspValidxSO), 64'(1));
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b1, '0, 1'b1, NREQ*DW'($urandom()), RND_W'({$urandom(), $urandom()}));
  endtask

  initial begin
    RstxRI = 1'b1; EnxSI = 1'b0; ReqValidxSI = '0; RndValidxSI = 1'b0;
    ReqDataxDI = '0; RndxDI = '0;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);

    // Single request on r0, X = 0x00 split as 0x5A/0x5A.
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, {16'h1234, 16'h5A5A}, RND_W'(48'hABCDEF012345));
    idle(5);

    // Both requesters always valid: grants must alternate.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, $urandom(), RND_W'({$urandom(), $urandom()}));
    idle(5);

    // Requests held while randomness is absent, then randomness arrives.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_3C3C, RND_W'({$urandom(), $urandom()}));
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_3C3C, RND_W'({$urandom(), $urandom()}));
    idle(5);

    // Reset while ops are in flight drops them.
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, $urandom(), RND_W'({$urandom(), $urandom()}));
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b1, $urandom(), RND_W'({$urandom(), $urandom()}));
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b1, $urandom(), RND_W'({$urandom(), $urandom()}));
    idle(6);

    // Randomness drops right after an issue: error goes sticky, response still delivered.
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b1, $urandom(), RND_W'({$urandom(), $urandom()}));
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, $urandom(), RND_W'({$urandom(), $urandom()}));
    idle(6);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, '0, '0);

    // Randomized traffic, including enable gaps, randomness gaps and occasional reset.
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom() % 100) == 0, ($urandom() % 8) != 0, NREQ'($urandom()),
                    ($urandom() % 10) != 0, $urandom(), RND_W'({$urandom(), $urandom()}));

    idle(8);
    checkOutput("DrainEmpty", 64'(expQ.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
